// File: rtl/fetch_buffer_pkg.sv
// Shared types for the instruction fetch buffer and the decoder-side packets.
// Holds the default depth and the {inst, pc} entry record.
package fetch_buffer_pkg;

  localparam int FB_DEPTH_DEFAULT = 8;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fb_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-side and decode-side signals of the fetch buffer.
// The buffer uses the slave modport; the fetch/decode driver uses master.
interface fetch_buffer_if;
  logic        flush;
  logic        fetch_valid;
  logic        fetch_two;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst0;
  logic [31:0] fetch_inst1;
  logic        fetch_ready;
  logic        dec0_valid;
  logic        dec1_valid;
  logic [31:0] dec0_inst;
  logic [31:0] dec0_pc;
  logic [31:0] dec1_inst;
  logic [31:0] dec1_pc;
  logic [1:0]  dec_take;

  modport slave (
    input  flush, fetch_valid, fetch_two, fetch_pc, fetch_inst0, fetch_inst1, dec_take,
    output fetch_ready, dec0_valid, dec1_valid, dec0_inst, dec0_pc, dec1_inst, dec1_pc
  );

  modport master (
    output flush, fetch_valid, fetch_two, fetch_pc, fetch_inst0, fetch_inst1, dec_take,
    input  fetch_ready, dec0_valid, dec1_valid, dec0_inst, dec0_pc, dec1_inst, dec1_pc
  );
endinterface

// File: rtl/fetch_buffer.sv
// Two-wide instruction fetch buffer: a circular queue of {inst, pc} entries
// filled by up to two fetched instructions per cycle and drained by two decode lanes.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  fetch_buffer_if.slave  fb
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  fb_entry_t     mem_q [DEPTH];

  logic          enq;
  logic [1:0]    enq_n;
  logic [AW-1:0] head_p1;
  logic [AW-1:0] tail_p1;

  // Ready looks only at the registered count, so a same-cycle dequeue never
  // makes room for a same-cycle enqueue.
  assign fb.fetch_ready = (count_q <= CW'(DEPTH - 2));

  assign enq     = fb.fetch_valid && fb.fetch_ready && !fb.flush;
  assign enq_n   = enq ? (fb.fetch_two ? 2'd2 : 2'd1) : 2'd0;
  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);

  always_comb begin
    head_d  = head_q + AW'(fb.dec_take);
    tail_d  = tail_q + AW'(enq_n);
    count_d = count_q - CW'(fb.dec_take) + CW'(enq_n);
    if (fb.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the entry array has no reset; head/tail/count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (enq && !rst) begin
      mem_q[tail_q] <= '{inst: fb.fetch_inst0, pc: fb.fetch_pc};
      if (fb.fetch_two) begin
        mem_q[tail_p1] <= '{inst: fb.fetch_inst1, pc: fb.fetch_pc + 32'd4};
      end
    end
  end

  assign fb.dec0_valid = (count_q >= CW'(1));
  assign fb.dec1_valid = (count_q >= CW'(2));
  assign fb.dec0_inst  = mem_q[head_q].inst;
  assign fb.dec0_pc    = mem_q[head_q].pc;
  assign fb.dec1_inst  = mem_q[head_p1].inst;
  assign fb.dec1_pc    = mem_q[head_p1].pc;

  // Decode may never take more entries than are presented, and never three.
  a_dec_take_legal : assert property (
    @(posedge clk) disable iff (rst)
    (fb.dec_take != 2'b11) && (CW'(fb.dec_take) <= count_q)
  );

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter: DEPTH, 8, number of instruction entries; power of two, at least 4.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: flush  input  1  redirect/mispredict; discard all buffered instructions.
REQ-005 Port: fetch_valid  input  1  fetch packet present this cycle.
REQ-006 Port: fetch_two  input  1  packet holds two instructions when 1, one when 0.
REQ-007 Port: fetch_pc  input  32  PC of slot 0; slot 1 PC is fetch_pc+4.
REQ-008 Port: fetch_inst0 / fetch_inst1  input  32 each  instruction words, slot 0 then slot 1.
REQ-009 Port: fetch_ready  output  1  buffer can accept a two-instruction packet this cycle.
REQ-010 Port: dec0_valid / dec1_valid  output  1 each  oldest / second-oldest entry valid.
REQ-011 Port: dec0_inst, dec0_pc, dec1_inst, dec1_pc  output  32 each  inst/pc pairs presented to the two decoder lanes.
REQ-012 Port: dec_take  input  2  entries consumed by decode this cycle (0, 1 or 2).

Function
REQ-013 Storage SHALL be a circular queue of DEPTH {inst, pc} entries with head, tail and a count of log2(DEPTH)+1 bits.
REQ-014 fetch_ready SHALL be 1 iff DEPTH-count >= 2, evaluated on registered state only, with no combinational path from fetch_* or dec_take.
REQ-015 Enqueue SHALL occur when fetch_valid && fetch_ready && !flush: slot 0 is written at tail; if fetch_two, slot 1 is written at tail+1 with pc = fetch_pc+4 (32-bit wrap); tail advances by 1 or 2 modulo DEPTH.
REQ-016 fetch_valid while fetch_ready=0 SHALL be ignored, with no state change; the fetch unit holds and retries.
REQ-017 dec0_* SHALL show the entry at head and dec1_* the entry at head+1 (mod DEPTH), combinationally from registered state; dec0_valid = count>=1 and dec1_valid = count>=2.
REQ-018 Dequeue SHALL advance head by dec_take modulo DEPTH.
REQ-019 dec_take greater than the number of valid lanes, or dec_take=2'b11, is illegal and SHALL be flagged by an assertion; the RTL need not handle it.
REQ-020 When dequeue and enqueue occur in the same cycle, count SHALL become count - dec_take + enq_n, including when full or empty at the start of the cycle.
REQ-021 Dequeue in a cycle SHALL NOT free space for an enqueue in that same cycle.
REQ-022 flush SHALL set head=tail=count=0 at the next edge, dropping any same-cycle enqueue and dequeue; dec*_valid is 0 in the following cycle.
REQ-023 Latency: an enqueued instruction SHALL appear on dec0/dec1 in the cycle after the write edge, with no bypass.
REQ-024 Pointer wrap: an entry pair straddling index DEPTH-1 and 0 SHALL be written and read in correct order.
REQ-025 Stored inst/pc SHALL be passed through unmodified; no decoding happens in this block.
REQ-026 When a lane is invalid, its inst and pc outputs are don't-care; the bench SHALL NOT check them.

Reset
REQ-027 On rst at a clock edge: head=0, tail=0, count=0, so dec0_valid=0, dec1_valid=0 and fetch_ready=1 in the next cycle.
REQ-028 rst SHALL take priority over flush, enqueue and dequeue.
REQ-029 Entry storage array SHALL NOT be reset.

Structure
REQ-030 The shared package SHALL hold FB_DEPTH_DEFAULT (8) and the typedef fb_entry_t {logic [31:0] inst; logic [31:0] pc}, so the entry type is shared with the decoder-side packet types.
REQ-031 The module SHALL be a single module with no sub-modules; pointer arithmetic and the storage array are inline.

Verification
REQ-032 Reset then idle: dec0_valid=0, dec1_valid=0, fetch_ready=1 for 5 cycles.
REQ-033 Enqueue pc=0x1000, two instructions 0x00500093 and 0x00A00113, with dec_take=0: next cycle dec0 = (0x00500093, 0x1000) and dec1 = (0x00A00113, 0x1004); dec_take=2 then empties the buffer.
REQ-034 Fill with four two-instruction packets (DEPTH=8): fetch_ready=0; a fifth packet is ignored; dec_take=1 leaves fetch_ready=0 (count 7); a second dec_take=1 raises fetch_ready (count 6).
REQ-035 Wrap: sustain enqueue of 2 and dequeue of 2 for 20 cycles; PCs on the decoder lanes increase strictly by 4 with no gaps or duplicates.
REQ-036 flush with count=5 and simultaneous fetch_valid and dec_take=1: next cycle both lanes are invalid and count=0; a following packet at pc=0x2000 appears first on dec0.
REQ-037 Single-instruction packets (fetch_two=0) interleaved with pairs keep slot order; PC 0xFFFFFFFC with fetch_two=1 yields a slot-1 PC of 0x00000000.
